pc_fetch_sequencer: RTL and testbench

Sequences the program counter and the instruction-memory fetch for the RV32I core. It issues one fetch at a time, advances PC by 4 using the PC-increment adder, and loads the branch-adder result on a redirect. Fetched instructions are presented to decode over a valid/ready handshake. The block sits between the PC/branch adders, instruction memory and the decode stage.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_next_adder.sv | 13 +
 rtl/pc_fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the RV32I program-counter / fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch targets must be word aligned; any low bit set is reported.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_adder.sv
// Combinational WIDTH-bit adder used for the sequential pc + INSTR_BYTES step.
module pc_next_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  // Modulo 2^WIDTH sum; the carry out is intentionally dropped.
  assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: one outstanding instruction fetch, redirect
// handling with kill of stale responses, and a valid/ready hand-off to decode.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             misalign
);

  fetch_state_t     state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] fetch_pc_q;
  logic             kill_q;
  logic [31:0]      instr_q;
  logic [WIDTH-1:0] instr_pc_q;
  logic             instr_valid_q;
  logic             misalign_q;

  logic [WIDTH-1:0] pc_inc_d;
  logic [WIDTH-1:0] redir_pc_d;

  pc_next_adder #(
    .WIDTH (WIDTH)
  ) u_pc_inc (
    .a_i   (pc_q),
    .b_i   (WIDTH'(INSTR_BYTES)),
    .sum_o (pc_inc_d)
  );

  // Redirect targets are forced onto a word boundary before loading pc.
  assign redir_pc_d = {redirect_target[WIDTH-1:2], 2'b00};

  // Fetch FSM: pc, in-flight bookkeeping and the held decode instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= {WIDTH{1'b0}};
      kill_q        <= 1'b0;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= {WIDTH{1'b0}};
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= redirect & is_misaligned(redirect_target[1:0]);
      case (state_q)
        BOOT: begin
          if (redirect) begin
            pc_q <= redir_pc_d;
          end
          state_q <= REQ;
        end
        REQ: begin
          if (imem_gnt) begin
            fetch_pc_q <= pc_q;
            pc_q       <= redirect ? redir_pc_d : pc_inc_d;
            kill_q     <= redirect;
            state_q    <= WAIT;
          end else if (redirect) begin
            pc_q <= redir_pc_d;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            // A response for a fetch overtaken by a redirect is dropped.
            if (kill_q || redirect) begin
              kill_q  <= 1'b0;
              if (redirect) begin
                pc_q <= redir_pc_d;
              end
              state_q <= REQ;
            end else begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= fetch_pc_q;
              instr_valid_q <= 1'b1;
              state_q       <= HOLD;
            end
          end else if (redirect) begin
            pc_q   <= redir_pc_d;
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
            pc_q          <= redir_pc_d;
            state_q       <= REQ;
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= REQ;
          end
        end
        default: begin
          state_q       <= BOOT;
          instr_valid_q <= 1'b0;
          kill_q        <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a transaction-level model of the fetch sequencer.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0, redirect_target = 32'h0;

  logic        req_a, valid_a, mis_a;
  logic [31:0] addr_a, instr_a, ipc_a;
  logic        req_b, valid_b, mis_b;
  logic [31:0] addr_b, instr_b, ipc_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(valid_a), .instr_ready(instr_ready), .instr(instr_a),
    .instr_pc(ipc_a), .misalign(mis_a));

  pc_fetch_sequencer #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(valid_b), .instr_ready(instr_ready), .instr(instr_b),
    .instr_pc(ipc_b), .misalign(mis_b));

  // Transaction-level reference: what is outstanding, what decode holds.
  logic        m_booting, m_in_flight, m_dead, m_holding, m_mis;
  logic [31:0] m_pc, m_flight_addr, m_instr, m_instr_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booting = 1'b1; m_in_flight = 1'b0; m_dead = 1'b0; m_holding = 1'b0; m_mis = 1'b0;
    m_pc = 32'h0; m_flight_addr = 32'h0; m_instr = 32'h0; m_instr_pc = 32'h0;
  endtask

  task automatic model_clock(input logic g, rv, rd, rdir, input logic [31:0] tgt, data);
    logic [31:0] word_tgt;
    word_tgt = tgt & 32'hFFFF_FFFC;
    m_mis = rdir && (tgt % 32'd4 != 32'd0);
    if (m_booting) begin
      m_booting = 1'b0;
      if (rdir) m_pc = word_tgt;
    end else if (m_holding) begin
      if (rdir) begin m_holding = 1'b0; m_pc = word_tgt; end
      else if (rd) m_holding = 1'b0;
    end else if (m_in_flight) begin
      if (rv) begin
        m_in_flight = 1'b0;
        if (rdir) m_pc = word_tgt;
        else if (!m_dead) begin
          m_holding = 1'b1; m_instr = data; m_instr_pc = m_flight_addr;
        end
        m_dead = 1'b0;
      end else if (rdir) begin
        m_pc = word_tgt; m_dead = 1'b1;
      end
    end else begin
      if (g) begin
        m_flight_addr = m_pc; m_in_flight = 1'b1; m_dead = rdir;
        m_pc = rdir ? word_tgt : m_pc + 32'd4;
      end else if (rdir) m_pc = word_tgt;
    end
  endtask

  task automatic check_model();
    chk("model_req",   32'(req_a), 32'(!m_booting && !m_in_flight && !m_holding));
    chk("model_addr",  addr_a, m_pc);
    chk("model_valid", 32'(valid_a), 32'(m_holding));
    chk("model_instr", instr_a, m_instr);
    chk("model_ipc",   ipc_a, m_instr_pc);
    chk("model_mis",   32'(mis_a), 32'(m_mis));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic g, rv, rd, rdir, input logic [31:0] tgt, data);
    imem_gnt = g; imem_rvalid = rv; instr_ready = rd; redirect = rdir;
    redirect_target = tgt; imem_rdata = data;
    @(posedge clk);
    model_clock(g, rv, rd, rdir, tgt, data);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_target = 32'h0; imem_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    check_model();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        gnt, rvalid, ready, redir;
    logic [31:0] tgt, rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_ipc;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t tied(input int i, input logic rq, input logic [31:0] ad,
                                input logic v, input logic [31:0] ins, input logic [31:0] ipc);
    vec_t r;
    r.gnt = 1'b1; r.rvalid = 1'b1; r.ready = 1'b1; r.redir = 1'b0;
    r.tgt = 32'h0; r.rdata = 32'hA5A5_0000 | 32'(i);
    r.e_req = rq; r.e_addr = ad; r.e_valid = v; r.e_instr = ins; r.e_ipc = ipc;
    return r;
  endfunction

  task automatic run_rows(input int n, input bit checked);
    for (int i = 0; i < n; i++) begin
      step(tbl[i].gnt, tbl[i].rvalid, tbl[i].ready, tbl[i].redir, tbl[i].tgt, tbl[i].rdata);
      if (checked) begin
        chk($sformatf("tbl%0d_req", i),   32'(req_a), 32'(tbl[i].e_req));
        chk($sformatf("tbl%0d_addr", i),  addr_a, tbl[i].e_addr);
        chk($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].e_valid));
        chk($sformatf("tbl%0d_instr", i), instr_a, tbl[i].e_instr);
        chk($sformatf("tbl%0d_ipc", i),   ipc_a, tbl[i].e_ipc);
        if (i == 0) chk("wrap_first_fetch", addr_b, 32'hFFFF_FFFC);
        if (i == 3) chk("wrap_second_fetch", addr_b, 32'h0000_0000);
      end
    end
  endtask

  initial begin
    tbl[0] = tied(0, 1'b1, 32'h0, 1'b0, 32'h0,         32'h0);
    tbl[1] = tied(1, 1'b0, 32'h4, 1'b0, 32'h0,         32'h0);
    tbl[2] = tied(2, 1'b0, 32'h4, 1'b1, 32'hA5A5_0002, 32'h0);
    tbl[3] = tied(3, 1'b1, 32'h4, 1'b0, 32'hA5A5_0002, 32'h0);
    tbl[4] = tied(4, 1'b0, 32'h8, 1'b0, 32'hA5A5_0002, 32'h0);
    tbl[5] = tied(5, 1'b0, 32'h8, 1'b1, 32'hA5A5_0005, 32'h4);
    tbl[6] = tied(6, 1'b1, 32'h8, 1'b0, 32'hA5A5_0005, 32'h4);
    tbl[7] = tied(7, 1'b0, 32'hC, 1'b0, 32'hA5A5_0005, 32'h4);
    tbl[8] = tied(8, 1'b0, 32'hC, 1'b1, 32'hA5A5_0008, 32'h8);

    // Reset values, then back-to-back fetches with everything tied high.
    do_reset();
    chk("rst_req", 32'(req_a), 32'h0);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_wrap_addr", addr_b, 32'hFFFF_FFFC);
    run_rows(9, 1'b1);

    // Redirect while decode holds instr_pc 4: instruction dropped.
    do_reset();
    run_rows(6, 1'b0);
    chk("hold_pre_ipc", ipc_a, 32'h4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0);
    chk("hold_redir_valid", 32'(valid_a), 32'h0);
    chk("hold_redir_req", 32'(req_a), 32'h1);
    chk("hold_redir_addr", addr_a, 32'h0000_0040);

    // Redirect in WAIT, response two cycles later is discarded.
    do_reset();
    run_rows(2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0);
    chk("wait_redir_addr", addr_a, 32'h0000_0080);
    chk("wait_redir_req", 32'(req_a), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("wait_kill_valid", 32'(valid_a), 32'h0);
    chk("wait_kill_req", 32'(req_a), 32'h1);
    chk("wait_kill_addr", addr_a, 32'h0000_0080);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("wait_kill_valid2", 32'(valid_a), 32'h0);

    // Decode stalls for five cycles; instruction must stay put.
    do_reset();
    run_rows(3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
      chk("stall_valid", 32'(valid_a), 32'h1);
      chk("stall_instr", instr_a, 32'hA5A5_0002);
      chk("stall_ipc", ipc_a, 32'h0);
      chk("stall_req", 32'(req_a), 32'h0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("stall_release_valid", 32'(valid_a), 32'h0);

    // Misaligned redirect target.
    do_reset();
    run_rows(1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0106, 32'h0);
    chk("mis_addr", addr_a, 32'h0000_0104);
    chk("mis_pulse", 32'(mis_a), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mis_pulse_end", 32'(mis_a), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFE_0104);
    chk("mis_fetch_ipc", ipc_a, 32'h0000_0104);

    // Asynchronous reset while a fetch is in flight.
    do_reset();
    run_rows(5, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(req_a), 32'h0);
    chk("async_rst_addr", addr_a, 32'h0);
    chk("async_rst_valid", 32'(valid_a), 32'h0);
    chk("async_rst_instr", instr_a, 32'h0);
    chk("async_rst_ipc", ipc_a, 32'h0);
    chk("async_rst_mis", 32'(mis_a), 32'h0);
    chk("async_rst_wrap_addr", addr_b, 32'hFFFF_FFFC);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hBAD0_0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hBAD0_0000);
    chk("stale_rvalid_valid", 32'(valid_a), 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
